uart_reg_bridge: RTL and testbench



---
 rtl/uart_bridge_pkg.sv | 46 ++++
 rtl/uart_reg_bridge_regfile.sv | 35 +++
 rtl/uart_reg_bridge.sv | 156 +++++++++++++++
 tb/tb_uart_reg_bridge.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared constants for the UART register bridge:
// command/reply bytes, FSM states, palette defaults.
package uart_bridge_pkg;

    localparam int REG_BYTES     = 32;
    localparam int PALETTE_BYTES = 24;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_EXEC,
        ST_SEND
    } state_t;

    // Colours are {B,G,R}
    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'h00FFFF;
    localparam logic [23:0] COL_CYAN    = 24'hFFFF00;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'h0000FF;
    localparam logic [23:0] COL_BLUE    = 24'hFF0000;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    localparam logic [191:0] PALETTE_DEFAULT = {
        COL_BLACK, COL_BLUE, COL_RED, COL_MAGENTA,
        COL_GREEN, COL_CYAN, COL_YELLOW, COL_WHITE
    };

    // Power-on value of register byte idx
    function automatic logic [7:0] reset_byte(input int idx);
        logic [191:0] p;
        p = PALETTE_DEFAULT;
        if (idx < PALETTE_BYTES) begin
            return p[idx*8 +: 8];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/uart_reg_bridge_regfile.sv
// 32x8 register file: one write port, one async read port,
// and a flat view of the palette bytes.
module bridge_regfile
    import uart_bridge_pkg::*;
(
    input  logic         I_clk,
    input  logic         I_rst_n,
    input  logic         we,
    input  logic [4:0]   waddr,
    input  logic [7:0]   wdata,
    input  logic [4:0]   raddr,
    output logic [7:0]   rdata,
    output logic [191:0] palette
);

    logic [7:0] mem [REG_BYTES];

    // Storage with reset to the default colour bars
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int i = 0; i < REG_BYTES; i++) begin
                mem[i] <= reset_byte(i);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

    for (genvar g = 0; g < PALETTE_BYTES; g++) begin : g_pal
        assign palette[g*8 +: 8] = mem[g];
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// Framed read/write command responder over UART byte
// handshakes, fronting the palette register file.
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYC = 270000
) (
    input  logic         I_clk,
    input  logic         I_rst_n,
    input  logic [7:0]   I_rx_data,
    input  logic         I_rx_data_valid,
    output logic         O_rx_data_ready,
    output logic [7:0]   O_tx_data,
    output logic         O_tx_data_valid,
    input  logic         I_tx_data_ready,
    output logic [191:0] O_palette,
    output logic         O_wr_strobe,
    output logic [4:0]   O_wr_addr,
    output logic         O_frame_err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [7:0]    cmd;
    logic [7:0]    addr;
    logic [7:0]    data;
    logic [7:0]    rdata;
    logic [7:0]    reply;
    logic          accept;
    logic          cmd_known;
    logic          addr_ok;
    logic          we;
    logic          timeout;

    assign O_rx_data_ready = (state == ST_IDLE) ||
                             (state == ST_GET_ADDR) ||
                             (state == ST_GET_DATA);
    assign accept    = I_rx_data_valid && O_rx_data_ready;
    assign cmd_known = (cmd == CMD_WRITE) || (cmd == CMD_READ);
    assign addr_ok   = (addr[7:5] == 3'b000);

    bridge_regfile u_regfile (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .we      (we),
        .waddr   (addr[4:0]),
        .wdata   (data),
        .raddr   (addr[4:0]),
        .rdata   (rdata),
        .palette (O_palette)
    );

    // State and timeout counter registers
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state, timeout, write enable and reply byte
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        we         = 1'b0;
        timeout    = 1'b0;
        reply      = RSP_ERR;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if ((I_rx_data == CMD_WRITE) ||
                        (I_rx_data == CMD_READ)) begin
                        state_next = ST_GET_ADDR;
                    end else begin
                        state_next = ST_EXEC;
                    end
                end
            end
            ST_GET_ADDR, ST_GET_DATA: begin
                if (accept) begin
                    if (state == ST_GET_ADDR && cmd == CMD_WRITE) begin
                        state_next = ST_GET_DATA;
                    end else begin
                        state_next = ST_EXEC;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_IDLE;
                    timeout    = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ST_EXEC: begin
                state_next = ST_SEND;
                if (cmd_known && addr_ok) begin
                    if (cmd == CMD_WRITE) begin
                        we    = 1'b1;
                        reply = RSP_OK;
                    end else begin
                        reply = rdata;
                    end
                end
            end
            ST_SEND: begin
                if (I_tx_data_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Frame capture and registered reply/strobe outputs
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cmd             <= 8'h00;
            addr            <= 8'h00;
            data            <= 8'h00;
            O_tx_data       <= 8'h00;
            O_tx_data_valid <= 1'b0;
            O_wr_strobe     <= 1'b0;
            O_wr_addr       <= 5'd0;
            O_frame_err     <= 1'b0;
        end else begin
            O_wr_strobe <= we;
            O_frame_err <= timeout;
            if (we) begin
                O_wr_addr <= addr[4:0];
            end
            if (accept && state == ST_IDLE) begin
                cmd <= I_rx_data;
            end
            if (accept && state == ST_GET_ADDR) begin
                addr <= I_rx_data;
            end
            if (accept && state == ST_GET_DATA) begin
                data <= I_rx_data;
            end
            if (state == ST_EXEC) begin
                O_tx_data       <= reply;
                O_tx_data_valid <= 1'b1;
            end else if (state == ST_SEND && I_tx_data_ready) begin
                O_tx_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: byte-queue reference model
// checked every cycle plus directed literal checks.
module tb_uart_reg_bridge;

    localparam int TO = 16;
    localparam logic [191:0] DEF =
        192'h000000_FF0000_0000FF_FF00FF_00FF00_FFFF00_00FFFF_FFFFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b1;
    logic [191:0] palette;
    logic         wr_strobe;
    logic [4:0]   wr_addr;
    logic         frame_err;

    int total = 0;
    int bad = 0;

    uart_reg_bridge #(.TIMEOUT_CYC(TO)) dut (
        .I_clk           (clk),
        .I_rst_n         (rst_n),
        .I_rx_data       (rx_data),
        .I_rx_data_valid (rx_valid),
        .O_rx_data_ready (rx_ready),
        .O_tx_data       (tx_data),
        .O_tx_data_valid (tx_valid),
        .I_tx_data_ready (tx_ready),
        .O_palette       (palette),
        .O_wr_strobe     (wr_strobe),
        .O_wr_addr       (wr_addr),
        .O_frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [191:0] act,
                       input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_mem [32];
    logic [7:0] m_q [$];
    int         m_idle;
    bit         m_busy;
    bit         m_pending;
    bit         m_tx_valid;
    logic [7:0] m_tx_data;
    bit         m_strobe;
    logic [4:0] m_waddr;
    bit         m_ferr;

    function automatic logic [191:0] m_pal();
        logic [191:0] p;
        for (int i = 0; i < 24; i++) p[i*8 +: 8] = m_mem[i];
        return p;
    endfunction

    function automatic bit frame_done();
        if (m_q.size() == 0) return 0;
        if (m_q[0] == 8'h57) return m_q.size() == 3;
        if (m_q[0] == 8'h52) return m_q.size() == 2;
        return 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                m_mem[i] = (i < 24) ? DEF[i*8 +: 8] : 8'h00;
            m_q.delete();
            m_idle = 0;
            m_busy = 0;
            m_pending = 0;
            m_tx_valid = 0;
            m_tx_data = 8'h00;
            m_strobe = 0;
            m_waddr = 5'd0;
            m_ferr = 0;
        end else begin
            m_strobe = 0;
            m_ferr = 0;
            if (m_tx_valid) begin
                if (tx_ready) begin
                    m_tx_valid = 0;
                    m_busy = 0;
                end
            end else if (m_pending) begin
                m_pending = 0;
                m_tx_valid = 1;
                m_tx_data = 8'h3F;
                if ((m_q[0] == 8'h57 || m_q[0] == 8'h52) && m_q[1] < 32) begin
                    if (m_q[0] == 8'h57) begin
                        m_mem[m_q[1]] = m_q[2];
                        m_strobe = 1;
                        m_waddr = m_q[1][4:0];
                        m_tx_data = 8'h4B;
                    end else begin
                        m_tx_data = m_mem[m_q[1]];
                    end
                end
                m_q.delete();
            end else if (rx_valid) begin
                m_q.push_back(rx_data);
                m_idle = 0;
                if (frame_done()) begin
                    m_pending = 1;
                    m_busy = 1;
                end
            end else if (m_q.size() > 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_q.delete();
                    m_idle = 0;
                    m_ferr = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("rx_ready", rx_ready, !m_busy);
        chk("tx_valid", tx_valid, m_tx_valid);
        if (m_tx_valid) chk("tx_data", tx_data, m_tx_data);
        chk("palette", palette, m_pal());
        chk("wr_strobe", wr_strobe, m_strobe);
        chk("wr_addr", wr_addr, m_waddr);
        chk("frame_err", frame_err, m_ferr);
    end

    // ---------------- event counters ----------------
    int n_strobe = 0;
    int n_ferr = 0;
    int n_tx = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (wr_strobe) n_strobe++;
            if (frame_err) n_ferr++;
            if (tx_valid && tx_ready) n_tx++;
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!rx_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL rx_wait: ready never rose within 200 cycles");
        end
        rx_data = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic get_reply(output logic [7:0] b);
        int n = 0;
        b = 8'hxx;
        while (!tx_valid && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL tx_wait: no reply within 200 cycles");
        end else begin
            b = tx_data;
            step();
        end
    endtask

    task automatic do_read(input logic [7:0] a, output logic [7:0] r);
        send_byte(8'h52);
        send_byte(a);
        get_reply(r);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                            output logic [7:0] r);
        send_byte(8'h57);
        send_byte(a);
        send_byte(d);
        get_reply(r);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0]   r;
        logic [191:0] def_v;
        logic [191:0] snap;
        logic [7:0]   held;
        int           s0;
        int           t0;
        int           f0;
        def_v = DEF;

        repeat (3) step();
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_palette", palette, def_v);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_wr_addr", wr_addr, 5'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 24; i++) begin
            do_read(8'(i), r);
            chk($sformatf("def_read_%0d", i), r, def_v[i*8 +: 8]);
        end
        chk("def_palette", palette, def_v);

        s0 = n_strobe;
        do_write(8'h03, 8'h80, r);
        chk("write_reply", r, 8'h4B);
        chk("write_strobes", n_strobe - s0, 1);
        chk("write_addr", wr_addr, 5'd3);
        chk("pal_byte3", palette[31:24], 8'h80);
        do_read(8'h03, r);
        chk("readback_3", r, 8'h80);

        snap = palette;
        s0 = n_strobe;
        send_byte(8'h58);
        get_reply(r);
        chk("bad_cmd", r, 8'h3F);
        do_write(8'h25, 8'h11, r);
        chk("bad_waddr", r, 8'h3F);
        do_read(8'hFF, r);
        chk("bad_raddr", r, 8'h3F);
        chk("bad_no_strobe", n_strobe - s0, 0);
        chk("bad_palette", palette, snap);

        f0 = n_ferr;
        t0 = n_tx;
        s0 = n_strobe;
        send_byte(8'h57);
        send_byte(8'h01);
        repeat (TO - 2) step();
        chk("to_early", n_ferr - f0, 0);
        repeat (10) step();
        chk("to_pulses", n_ferr - f0, 1);
        chk("to_no_reply", n_tx - t0, 0);
        chk("to_no_write", n_strobe - s0, 0);
        do_read(8'h01, r);
        chk("to_readback", r, 8'hFF);

        tx_ready = 1'b0;
        send_byte(8'h52);
        send_byte(8'h02);
        step();
        held = tx_data;
        t0 = n_tx;
        for (int i = 0; i < 50; i++) begin
            if (!tx_valid || tx_data !== held || rx_ready) begin
                total++;
                bad++;
                $display("FAIL stall_hold: cyc %0d valid %b data %h rdy %b",
                         i, tx_valid, tx_data, rx_ready);
            end
            step();
        end
        chk("stall_data", tx_data, 8'hFF);
        chk("stall_valid", tx_valid, 1'b1);
        chk("stall_rdy", rx_ready, 1'b0);
        tx_ready = 1'b1;
        step();
        chk("stall_xfers", n_tx - t0, 1);
        chk("stall_valid_drop", tx_valid, 1'b0);
        chk("stall_rdy_back", rx_ready, 1'b1);

        s0 = n_strobe;
        send_byte(8'h57);
        send_byte(8'h00);
        step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("rst_mid_strobe", n_strobe - s0, 0);
        chk("rst_mid_pal0", palette[23:0], 24'hFFFFFF);
        chk("rst_mid_rdy", rx_ready, 1'b1);
        chk("rst_mid_valid", tx_valid, 1'b0);
        do_read(8'h00, r);
        chk("rst_mid_read", r, 8'hFF);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
